// File: rtl/csc_serializer_pkg.sv
// Shared types and width helpers for the mix-output serializer and its FIFO.
package csc_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int DEF_NUM_DATA_BITS = 15;
  localparam int DEF_CLK_DIV       = 8;
  localparam int DEF_FIFO_DEPTH    = 4;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csc_serializer_if.sv
// Bundle between the output formatter, the serializer and the DAC-side serial pins.
interface csc_serializer_if
  import csc_serializer_pkg::*;
#(
  parameter int NUM_DATA_BITS = DEF_NUM_DATA_BITS,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
);
  // csc_data is captured on every clock where csc_data_en is high; there is no
  // ready, so the producer must keep to the word rate and fifo_full/overflow
  // report when it did not.
  logic [NUM_DATA_BITS-1:0]       csc_data;
  logic                           csc_data_en;
  logic                           ser_clk;
  logic                           ser_data;
  logic                           ser_frame;
  logic                           fifo_full;
  logic                           overflow;
  ser_state_t                     fsm_state;
  logic [cnt_w(FIFO_DEPTH):0]     fifo_level;

  modport master (
    output csc_data, csc_data_en,
    input  ser_clk, ser_data, ser_frame, fifo_full, overflow, fsm_state, fifo_level
  );

  modport slave (
    input  csc_data, csc_data_en,
    output ser_clk, ser_data, ser_frame, fifo_full, overflow, fsm_state, fifo_level
  );

endinterface

// File: rtl/csc_serializer_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read and registered full/empty flags.
module csc_serializer_sync_fifo
  import csc_serializer_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = cnt_w(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             wr_en;
  logic             rd_en;

  // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
  assign wr_en   = push && (!full || pop);
  assign rd_en   = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_en)      count_nxt = count + 1'b1;
    else if (!wr_en && rd_en) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/csc_serializer.sv
// Buffers mix words and shifts them out MSB-first on a bit-clock/data/frame serial link.
module csc_serializer
  import csc_serializer_pkg::*;
#(
  parameter int NUM_DATA_BITS = DEF_NUM_DATA_BITS,
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input logic              clk,
  input logic              rst,
  csc_serializer_if.slave  bus
);

  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam int BIT_W = cnt_w(NUM_DATA_BITS);
  localparam int CNT_W = cnt_w(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(NUM_DATA_BITS - 1);

  ser_state_t               state_q, state_n;
  logic [DIV_W-1:0]         div_q, div_n;
  logic [BIT_W-1:0]         bit_q, bit_n;
  logic                     phase_q, phase_n;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_n;
  logic                     ser_clk_q, ser_data_q, ser_frame_q, overflow_q;
  logic                     pop, drop;
  logic                     fifo_full, fifo_empty;
  logic [NUM_DATA_BITS-1:0] fifo_rd;
  logic [CNT_W-1:0]         fifo_count;

  csc_serializer_sync_fifo #(
    .WIDTH (NUM_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.csc_data_en),
    .pop     (pop),
    .wr_data (bus.csc_data),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign drop = bus.csc_data_en && fifo_full && !pop;

  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    bit_n   = bit_q;
    phase_n = phase_q;
    shift_n = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = SHIFT;
          shift_n = fifo_rd;
          bit_n   = BIT_MSB;
          div_n   = '0;
          phase_n = 1'b0;
        end
      end
      SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_n = div_q + 1'b1;
        end else begin
          div_n = '0;
          if (!phase_q) begin
            phase_n = 1'b1;
          end else begin
            phase_n = 1'b0;
            // End of a bit: next bit, next word without a gap, or go quiet.
            if (bit_q != '0) begin
              bit_n   = bit_q - 1'b1;
              shift_n = {shift_q[NUM_DATA_BITS-2:0], 1'b0};
            end else if (!fifo_empty) begin
              pop     = 1'b1;
              shift_n = fifo_rd;
              bit_n   = BIT_MSB;
            end else begin
              state_n = IDLE;
              shift_n = '0;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      shift_q     <= '0;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_frame_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      div_q       <= div_n;
      bit_q       <= bit_n;
      phase_q     <= phase_n;
      shift_q     <= shift_n;
      ser_clk_q   <= (state_n == SHIFT) && phase_n;
      ser_data_q  <= (state_n == SHIFT) && shift_n[NUM_DATA_BITS-1];
      ser_frame_q <= (state_n == SHIFT) && (bit_n == BIT_MSB);
      overflow_q  <= overflow_q || drop;
    end
  end

  assign bus.ser_clk    = ser_clk_q;
  assign bus.ser_data   = ser_data_q;
  assign bus.ser_frame  = ser_frame_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.overflow   = overflow_q;
  assign bus.fsm_state  = state_q;
  assign bus.fifo_level = fifo_count;

endmodule

// File: doc/csc_serializer.md
Name: csc_serializer

Overview:
Consumer end of the mixer's summed-output interface. Accepts formatted mix words (data + one-cycle enable) from the output formatter, buffers them in a small FIFO, and shifts each word out MSB-first on a 3-wire serial link (bit clock, data, frame sync) toward the DAC/codec. Reports FIFO full and a sticky overflow flag for bring-up debugging.

Parameters:
NUM_DATA_BITS, 15, width of each input word and of each serial frame
CLK_DIV, 8, system clocks per half bit period (bit period = 2*CLK_DIV clocks); legal >= 1
FIFO_DEPTH, 4, word entries in the input FIFO; power of two, >= 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
csc_data  input  NUM_DATA_BITS  formatted mix word, two's complement
csc_data_en  input  1  one-cycle strobe; csc_data is valid and written when high
ser_clk  output  1  serial bit clock
ser_data  output  1  serial data, MSB first; changes only at bit start (ser_clk low phase)
ser_frame  output  1  high for exactly the MSB bit period of each word
fifo_full  output  1  FIFO holds FIFO_DEPTH words
overflow  output  1  sticky: a word was dropped; cleared only by rst

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- All outputs registered. Reset values: ser_clk=0, ser_data=0, ser_frame=0, fifo_full=0, overflow=0. FIFO pointers and count are cleared.
- Write: on csc_data_en=1, push csc_data unless the FIFO is full with no pop in the same cycle. A simultaneous push and pop when full is accepted and count is unchanged. A dropped write sets overflow=1 on the next cycle.
- FSM states:
  - IDLE: ser_clk=0, ser_data=0, ser_frame=0. If the FIFO is non-empty, pop into the shift register and go to SHIFT.
  - SHIFT: bit_cnt counts NUM_DATA_BITS-1 down to 0. div_cnt counts 0..CLK_DIV-1 per phase. Phase low (ser_clk=0) then phase high (ser_clk=1), so each bit lasts 2*CLK_DIV clocks. The receiver samples on the ser_clk rising edge.
- Latency: a write at cycle t into an empty FIFO in IDLE gives FIFO non-empty at t+1, the pop at t+1, and ser_frame=1 with ser_data=word MSB at t+2.
- End of word: at the last clock of bit 0's high phase:
  - If the FIFO is non-empty, pop and begin the next word's MSB on the very next clock. There is no gap and the ser_clk cadence is unbroken.
  - Otherwise return to IDLE.
- ser_frame asserts for the full 2*CLK_DIV clocks of the MSB bit only.
- A write arriving in the same cycle the FSM checks an empty FIFO is not seen until the next cycle. This costs one extra clock and is not an error.
- Reset mid-word: the next cycle shows reset values, the partial word is abandoned and the FIFO is flushed. No partial frame resumes.
- Throughput: the sustained input rate must be <= 1 word per NUM_DATA_BITS*2*CLK_DIV clocks. A faster rate fills the FIFO and then sets overflow.

Decomposition:
- Shared package/header:
  - FSM state encodings (IDLE, SHIFT)
  - clog2-derived widths for div_cnt, bit_cnt and FIFO pointers/count
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop, full/empty, count; synchronous reset). It is reusable for other stream buffers in the mixer.
- Serializer FSM, dividers and shift register stay in csc_serializer.

Test Plan:
- Reset and idle (CLK_DIV=2): hold rst 3 cycles, then no writes → all outputs 0 indefinitely; fifo_full=0, overflow=0.
- Single word (CLK_DIV=2): write 15'h5A3C at cycle t, then:
  - ser_frame=1 for cycles t+2..t+5
  - ser_data reads 101101000111100 MSB first, one bit per 4 clocks, stable across each ser_clk rising edge
  - return to IDLE at t+62
- Back-to-back: write 15'h7FFF, then 15'h0001 ten cycles later → the second frame starts on the clock after the first word's last bit (second ser_frame rise exactly 60 clocks after the first), with no ser_clk glitch.
- Overflow (FIFO_DEPTH=4): write 6 words on consecutive cycles, with word 1 popped at t+1, then:
  - fifo_full=1
  - word 6 is dropped and overflow=1 on the next cycle, staying 1
  - exactly 5 words are serialized, in order
- Full plus simultaneous pop: with the FIFO full, write in the same cycle the FSM pops → the word is accepted, overflow stays 0 and all 5 words are serialized.
- Reset mid-word: assert rst during bit 7 of a frame with 2 words queued → outputs are 0 on the next cycle, and no further serial activity occurs until a new write.
